branch_target_predictor: RTL and testbench

Parametrised set-associative branch target buffer with per-entry saturating direction counters. It replaces the separate multi-cycle btb and tournament_predictor pair in the fetch stage with a single fixed-latency block. IF issues a lookup with the fetch PC and gets a registered prediction one cycle later. MEM sends resolved branch outcomes back as updates. It adds associativity, tree-PLRU replacement, counter-width and size parameters, a stall hold and a one-cycle flush.

---
 rtl/branch_target_predictor_pkg.sv | 42 ++++
 rtl/branch_target_predictor_plru.sv | 94 +++++++++
 rtl/branch_target_predictor.sv | 164 ++++++++++++++++
 tb/tb_branch_target_predictor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// ============================================================================
// branch_target_predictor_pkg : BTB entry type and counter helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_target_predictor_pkg;

    // Sized for the widest supported geometry; unused upper bits are constant.
    localparam int TAG_MAX_W = 30;
    localparam int CTR_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [CTR_MAX_W-1:0] ctr;
    } btb_entry_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_sat(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 inc,
        input int                   bits
    );
        logic [CTR_MAX_W-1:0] max;
        logic [CTR_MAX_W-1:0] res;
        max = CTR_MAX_W'((9'd1 << bits) - 9'd1);
        if (inc) begin
            res = (ctr == max) ? ctr : ctr + 1'b1;
        end else begin
            res = (ctr == '0) ? ctr : ctr - 1'b1;
        end
        return res;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int bits);
        return CTR_MAX_W'(1) << (bits - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_predictor_plru.sv
// ============================================================================
// plru_tree : per-set tree pseudo-LRU state with two touch ports and a victim
// Rev 1.0
// ============================================================================
`default_nettype none

module plru_tree #(
    parameter int SETS  = 32,
    parameter int WAYS  = 2,
    parameter int IDX_W = 5,
    parameter int LW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_touch_a,
    input  logic [IDX_W-1:0] i_set_a,
    input  logic [LW-1:0]    i_way_a,
    input  logic             i_touch_b,
    input  logic [IDX_W-1:0] i_set_b,
    input  logic [LW-1:0]    i_way_b,
    input  logic [IDX_W-1:0] i_vic_set,
    output logic [LW-1:0]    o_vic_way
);

    // Heap-ordered tree: node 1 is the root, node n has children 2n and 2n+1.
    function automatic logic [WAYS-1:0] f_touch(input logic [WAYS-1:0] bits,
                                                input logic [LW-1:0]   way);
        logic [WAYS-1:0] b;
        int              node;
        b    = bits;
        node = 1;
        for (int l = 0; l < LW; l++) begin
            b[node] = ~way[LW-1-l];
            node    = 2 * node + int'(way[LW-1-l]);
        end
        return b;
    endfunction

    function automatic logic [LW-1:0] f_victim(input logic [WAYS-1:0] bits);
        logic [LW-1:0] w;
        logic          dir;
        int            node;
        w    = '0;
        node = 1;
        for (int l = 0; l < LW; l++) begin
            dir  = bits[node];
            w    = LW'({w, dir});
            node = 2 * node + int'(dir);
        end
        return w;
    endfunction

    generate
        if (WAYS > 1) begin : g_tree
            logic [WAYS-1:0] r_bits [SETS];
            logic [WAYS-1:0] w_next [SETS];

            // Touch b is applied last so it wins on a shared set.
            always_comb begin
                for (int s = 0; s < SETS; s++) begin
                    w_next[s] = r_bits[s];
                end
                if (i_touch_a) begin
                    w_next[i_set_a] = f_touch(w_next[i_set_a], i_way_a);
                end
                if (i_touch_b) begin
                    w_next[i_set_b] = f_touch(w_next[i_set_b], i_way_b);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        r_bits[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < SETS; s++) begin
                        r_bits[s] <= w_next[s];
                    end
                end
            end

            assign o_vic_way = f_victim(r_bits[i_vic_set]);
        end else begin : g_direct
            logic w_unused;
            assign w_unused  = ^{clk, rst_n, i_touch_a, i_set_a, i_way_a,
                                 i_touch_b, i_set_b, i_way_b, i_vic_set};
            assign o_vic_way = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// branch_target_predictor : set-associative BTB with saturating counters,
// single-cycle registered lookup, MEM-stage updates and one-cycle flush.
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic        stall,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic        resp_taken,
    output logic [31:0] resp_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IB    = $clog2(SETS);
    localparam int IDX_W = (IB > 0) ? IB : 1;
    localparam int LW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] pc);
        return (IB == 0) ? '0 : IDX_W'(pc >> 2);
    endfunction

    function automatic logic [TAG_MAX_W-1:0] f_tag(input logic [31:0] pc);
        return TAG_MAX_W'(pc >> (IB + 2));
    endfunction

    btb_entry_t r_mem [SETS][WAYS];

    logic                 r_resp_valid, r_resp_hit, r_resp_taken;
    logic [31:0]          r_resp_target;

    logic [IDX_W-1:0]     w_lk_idx, w_up_idx;
    logic [TAG_MAX_W-1:0] w_lk_tag, w_up_tag;
    logic [WAYS-1:0]      w_lk_hit_vec, w_up_hit_vec;
    logic [LW-1:0]        w_lk_way, w_up_hit_way, w_inv_way, w_vic_way, w_up_way;
    logic                 w_lk_hit, w_lk_taken, w_up_hit, w_any_inv;
    logic                 w_up_en, w_up_touch, w_lk_touch;

    assign w_lk_idx = f_idx(lookup_pc);
    assign w_lk_tag = f_tag(lookup_pc);
    assign w_up_idx = f_idx(update_pc);
    assign w_up_tag = f_tag(update_pc);

    // Allocation only happens on a miss, so at most one way can match.
    always_comb begin
        w_lk_hit_vec = '0;
        w_up_hit_vec = '0;
        w_lk_way     = '0;
        w_up_hit_way = '0;
        w_inv_way    = '0;
        w_any_inv    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            w_lk_hit_vec[w] = r_mem[w_lk_idx][w].valid && (r_mem[w_lk_idx][w].tag == w_lk_tag);
            w_up_hit_vec[w] = r_mem[w_up_idx][w].valid && (r_mem[w_up_idx][w].tag == w_up_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_lk_hit_vec[w]) w_lk_way = LW'(w);
            if (w_up_hit_vec[w]) w_up_hit_way = LW'(w);
            if (!r_mem[w_up_idx][w].valid) begin
                w_any_inv = 1'b1;
                w_inv_way = LW'(w);
            end
        end
    end

    assign w_lk_hit   = |w_lk_hit_vec;
    assign w_lk_taken = w_lk_hit && r_mem[w_lk_idx][w_lk_way].ctr[CTR_BITS-1];
    assign w_up_hit   = |w_up_hit_vec;
    assign w_up_way   = w_up_hit ? w_up_hit_way : (w_any_inv ? w_inv_way : w_vic_way);
    assign w_up_en    = update_valid && !flush;
    assign w_up_touch = w_up_en && (w_up_hit || update_taken);
    assign w_lk_touch = lookup_valid && !stall && !flush && w_lk_hit;

    plru_tree #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .LW    (LW)
    ) u_plru (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_touch_a (w_lk_touch),
        .i_set_a   (w_lk_idx),
        .i_way_a   (w_lk_way),
        .i_touch_b (w_up_touch),
        .i_set_b   (w_up_idx),
        .i_way_b   (w_up_way),
        .i_vic_set (w_up_idx),
        .o_vic_way (w_vic_way)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_mem[s][w] <= '0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_mem[s][w].valid <= 1'b0;
                end
            end
        end else if (w_up_en) begin
            if (w_up_hit) begin
                r_mem[w_up_idx][w_up_way].ctr <=
                    ctr_sat(r_mem[w_up_idx][w_up_way].ctr, update_taken, CTR_BITS);
                if (update_taken) begin
                    r_mem[w_up_idx][w_up_way].target <= update_target;
                end
            end else if (update_taken) begin
                r_mem[w_up_idx][w_up_way] <= '{valid:  1'b1,
                                                tag:    w_up_tag,
                                                target: update_target,
                                                ctr:    ctr_weak_taken(CTR_BITS)};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_taken  <= 1'b0;
            r_resp_target <= '0;
        end else if (flush) begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_taken  <= 1'b0;
        end else if (!stall) begin
            r_resp_valid  <= lookup_valid;
            r_resp_hit    <= w_lk_hit;
            r_resp_taken  <= w_lk_taken;
            r_resp_target <= w_lk_taken ? r_mem[w_lk_idx][w_lk_way].target
                                        : lookup_pc + 32'd4;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign resp_taken  = r_resp_taken;
    assign resp_target = r_resp_target;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// tb_branch_target_predictor : directed scoreboard bench for the BTB
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        resp_valid, resp_hit, resp_taken;
    logic [31:0] resp_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        flush;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .ENTRIES  (64),
        .WAYS     (2),
        .CTR_BITS (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .stall         (stall),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_taken    (resp_taken),
        .resp_target   (resp_target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush)
    );

    typedef struct {
        logic        v;
        logic        h;
        logic        t;
        logic [31:0] tgt;
        bit          vonly;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk1(string name, string field, logic [31:0] got, logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s.%s got %h expected %h", name, field, got, exp);
        end
    endtask

    task automatic expect_resp(string name, logic v, logic h, logic t,
                               logic [31:0] tgt, bit vonly);
        exp_t e;
        e.v = v; e.h = h; e.t = t; e.tgt = tgt; e.vonly = vonly; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_resp();
        exp_t e;
        if (sb.size() == 0) begin
            ntests++;
            nfail++;
            $error("FAIL scoreboard empty got resp_valid %0b expected an entry", resp_valid);
        end else begin
            e = sb.pop_front();
            chk1(e.name, "valid", 32'(resp_valid), 32'(e.v));
            if (!e.vonly) begin
                chk1(e.name, "hit",    32'(resp_hit),   32'(e.h));
                chk1(e.name, "taken",  32'(resp_taken), 32'(e.t));
                chk1(e.name, "target", resp_target,     e.tgt);
            end
        end
    endtask

    task automatic lookup(string name, logic [31:0] pc, logic h, logic t, logic [31:0] tgt);
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        expect_resp(name, 1'b1, h, t, tgt, 1'b0);
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        check_resp();
    endtask

    task automatic update(logic [31:0] pc, logic tk, logic [31:0] tgt);
        @(negedge clk);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        @(posedge clk);
        #1;
        update_valid  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_target = '0; flush = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset", "valid",  32'(resp_valid), 32'd0);
        chk1("reset", "hit",    32'(resp_hit),   32'd0);
        chk1("reset", "taken",  32'(resp_taken), 32'd0);
        chk1("reset", "target", resp_target,     32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Cold miss, and a not-taken update never allocates
        lookup("cold", 32'h100, 1'b0, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h200);
        lookup("nt_noalloc", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocation lands weakly taken
        update(32'h100, 1'b1, 32'h200);
        lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        // Counter walk including both saturation points
        update(32'h100, 1'b0, 32'h0);
        lookup("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h0);
        lookup("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h0);
        lookup("ctr00_sat", 32'h100, 1'b1, 1'b0, 32'h104);
        for (int i = 0; i < 3; i++) update(32'h100, 1'b1, 32'h200);
        lookup("ctr11", 32'h100, 1'b1, 1'b1, 32'h200);
        update(32'h100, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h0);
        lookup("ctr11_sat", 32'h100, 1'b1, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h0);
        lookup("ctr11_sat_b", 32'h100, 1'b1, 1'b0, 32'h104);

        // PLRU replacement: the lookup of 0x100 makes 0x180 the victim
        pulse_reset();
        update(32'h100, 1'b1, 32'h1000);
        update(32'h180, 1'b1, 32'h2000);
        lookup("repl_touch", 32'h100, 1'b1, 1'b1, 32'h1000);
        update(32'h200, 1'b1, 32'h3000);
        lookup("repl_evicted", 32'h180, 1'b0, 1'b0, 32'h184);
        lookup("repl_kept",    32'h100, 1'b1, 1'b1, 32'h1000);
        lookup("repl_new",     32'h200, 1'b1, 1'b1, 32'h3000);

        // Same-cycle lookup and update: read-before-write
        pulse_reset();
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h500;
        expect_resp("rbw", 1'b1, 1'b0, 1'b0, 32'h104, 1'b0);
        @(posedge clk);
        #1;
        lookup_valid = 1'b0; update_valid = 1'b0;
        check_resp();
        lookup("rbw_after", 32'h100, 1'b1, 1'b1, 32'h500);

        // Stall holds the response; an update during stall still lands
        @(negedge clk);
        stall = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h180;
        update_valid = 1'b1; update_pc = 32'h180; update_taken = 1'b1; update_target = 32'h600;
        for (int i = 0; i < 3; i++) begin
            expect_resp("stall_hold", 1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
            @(posedge clk);
            #1;
            update_valid = 1'b0;
            check_resp();
            @(negedge clk);
        end
        stall = 1'b0; lookup_valid = 1'b0;
        lookup("stall_update", 32'h180, 1'b1, 1'b1, 32'h600);

        // Flush beats a same-cycle update and lookup
        @(negedge clk);
        flush = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h100;
        update_valid = 1'b1; update_pc = 32'h300; update_taken = 1'b1; update_target = 32'h900;
        expect_resp("flush", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
        check_resp();
        lookup("flush_100", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("flush_300", 32'h300, 1'b0, 1'b0, 32'h304);

        // Asynchronous reset between a lookup and its response
        update(32'h100, 1'b1, 32'h700);
        lookup("pre_reset", 32'h100, 1'b1, 1'b1, 32'h700);
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        #2 reset_n = 1'b0;
        #1;
        chk1("async_reset", "valid",  32'(resp_valid), 32'd0);
        chk1("async_reset", "hit",    32'(resp_hit),   32'd0);
        chk1("async_reset", "target", resp_target,     32'd0);
        @(posedge clk);
        #1;
        chk1("reset_discard", "valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; lookup_valid = 1'b0;
        lookup("post_reset", 32'h100, 1'b0, 1'b0, 32'h104);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
